// File: rtl/dose_timer.sv
// Dose timer: times each ingredient dose of the brewing FSM and pulses result when it completes.
// Optional DOSE_TIMER_PAUSE_EN adds a pause input that freezes an in-progress dose.
module dose_timer #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       state_in,
    input  logic [1:0]       recipe,
`ifdef DOSE_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             result,
    output logic [CNT_W-1:0] remaining,
    output logic             dose_active,
    output logic [1:0]       timer_state
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_r;
    logic [PRE_W-1:0] presc_r;
    logic [1:0]       recipe_r;
    logic [2:0]       active_r;
    logic             result_r;
    logic             dose_active_r;
    logic [CNT_W-1:0] remaining_r;

    logic             pause_s;
    logic             valid_in_s;
    logic [1:0]       eff_recipe_s;
    logic [CNT_W-1:0] dose_s;

    function automatic logic [CNT_W-1:0] dose_lookup(input logic [1:0] rcp, input logic [2:0] ing);
        logic [3:0] d;
        d = 4'd0;
        case ({rcp, ing})
            5'b00_000: d = 4'd8;
            5'b00_001: d = 4'd4;
            5'b01_000: d = 4'd8;
            5'b01_001: d = 4'd4;
            5'b01_010: d = 4'd2;
            5'b10_000: d = 4'd6;
            5'b10_001: d = 4'd4;
            5'b10_010: d = 4'd2;
            5'b10_011: d = 4'd6;
            5'b11_000: d = 4'd6;
            5'b11_001: d = 4'd4;
            5'b11_010: d = 4'd2;
            5'b11_011: d = 4'd4;
            5'b11_100: d = 4'd3;
            default:   d = 4'd0;
        endcase
        return CNT_W'(d);
    endfunction

    // Pause source, input qualification and dose selection (recipe is taken live only at water)
    always_comb begin
`ifdef DOSE_TIMER_PAUSE_EN
        pause_s = pause;
`else
        pause_s = 1'b0;
`endif
        valid_in_s = (state_in <= 3'd4);
        if (state_in == 3'd0) begin
            eff_recipe_s = recipe;
        end else begin
            eff_recipe_s = recipe_r;
        end
        dose_s = dose_lookup(eff_recipe_s, state_in);
    end

    // Timer FSM with registered result/dose_active/remaining
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= IDLE;
            presc_r       <= '0;
            recipe_r      <= 2'd0;
            active_r      <= 3'b111;
            result_r      <= 1'b0;
            dose_active_r <= 1'b0;
            remaining_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    result_r      <= 1'b0;
                    dose_active_r <= 1'b0;
                    remaining_r   <= '0;
                    if (valid_in_s && (state_in != active_r)) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    presc_r <= '0;
                    if (!valid_in_s) begin
                        state_r       <= IDLE;
                        remaining_r   <= '0;
                        result_r      <= 1'b0;
                        dose_active_r <= 1'b0;
                    end else begin
                        active_r    <= state_in;
                        remaining_r <= dose_s;
                        if (state_in == 3'd0) begin
                            recipe_r <= recipe;
                        end
                        if (dose_s == '0) begin
                            state_r       <= DONE;
                            result_r      <= 1'b1;
                            dose_active_r <= 1'b0;
                        end else begin
                            state_r       <= COUNT;
                            result_r      <= 1'b0;
                            dose_active_r <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (state_in != active_r) begin
                        // Ingredient changed under us: drop this dose silently
                        result_r      <= 1'b0;
                        dose_active_r <= 1'b0;
                        remaining_r   <= '0;
                        presc_r       <= '0;
                        active_r      <= 3'b111;
                        if (valid_in_s) begin
                            state_r <= LOAD;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (pause_s) begin
                        state_r <= COUNT;
                    end else if (presc_r == PRE_LAST) begin
                        presc_r     <= '0;
                        remaining_r <= remaining_r - CNT_W'(1);
                        if (remaining_r == CNT_W'(1)) begin
                            state_r       <= DONE;
                            result_r      <= 1'b1;
                            dose_active_r <= 1'b0;
                        end else begin
                            state_r <= COUNT;
                        end
                    end else begin
                        presc_r <= presc_r + PRE_W'(1);
                    end
                end
                DONE: begin
                    state_r       <= IDLE;
                    result_r      <= 1'b0;
                    dose_active_r <= 1'b0;
                    remaining_r   <= '0;
                end
                default: begin
                    state_r       <= IDLE;
                    result_r      <= 1'b0;
                    dose_active_r <= 1'b0;
                    remaining_r   <= '0;
                end
            endcase
        end
    end

    assign result      = result_r;
    assign remaining   = remaining_r;
    assign dose_active = dose_active_r;
    assign timer_state = state_r;

endmodule

// File: tb/tb_dose_timer.sv
// Directed bench for dose_timer with TICK_DIV=4, CNT_W=8; covers DOSE_TIMER_PAUSE_EN when defined.
module tb_dose_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] state_in = 3'd0;
    logic [1:0] recipe = 2'd0;
`ifdef DOSE_TIMER_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       result;
    logic [7:0] remaining;
    logic       dose_active;
    logic [1:0] timer_state;

    int checks = 0;
    int errors = 0;
    int npulse;
    int nd;
    int first_off;
    logic [7:0] doses [0:7];

    dose_timer #(.TICK_DIV(4), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .state_in    (state_in),
        .recipe      (recipe),
`ifdef DOSE_TIMER_PAUSE_EN
        .pause       (pause),
`endif
        .result      (result),
        .remaining   (remaining),
        .dose_active (dose_active),
        .timer_state (timer_state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
    endtask

    // Closed loop with a minimal brewing FSM that advances on each result pulse
    task automatic brew(input logic [1:0] rcp, input bit swap);
        logic prev_act;
        do_reset();
        recipe   = rcp;
        state_in = 3'd0;
        reset    = 1'b1;
        npulse   = 0;
        nd       = 0;
        prev_act = 1'b0;
        for (int i = 0; i < 600 && state_in != 3'd5; i++) begin
            step();
            if (dose_active && !prev_act && nd < 8) begin
                doses[nd] = remaining;
                nd++;
            end
            prev_act = dose_active;
            if (swap && state_in == 3'd1 && dose_active) recipe = 2'd0;
            if (result) begin
                npulse++;
                state_in = state_in + 3'd1;
            end
        end
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_state", timer_state, 2'b00);
        chk("rst_remaining", remaining, 8'd0);
        chk("rst_result", result, 1'b0);
        chk("rst_active", dose_active, 1'b0);

        // Water dose, recipe 0: 8 ticks -> pulse 33 cycles after LOAD
        recipe = 2'd0; state_in = 3'd0; reset = 1'b1;
        step();
        chk("load_after_release", timer_state, 2'b01);
        first_off = -1; npulse = 0;
        for (int off = 1; off <= 80; off++) begin
            step();
            if (off == 1) begin
                chk("water_remaining", remaining, 8'd8);
                chk("water_count_state", timer_state, 2'b10);
                chk("water_dose_active", dose_active, 1'b1);
            end
            if (result) begin
                npulse++;
                if (first_off < 0) first_off = off;
            end
        end
        chk("water_pulse_offset", first_off, 33);
        chk("water_pulse_count", npulse, 1);
        chk("water_idle_after", timer_state, 2'b00);
        chk("water_remaining_after", remaining, 8'd0);

        // Reset mid-COUNT at remaining=3
        do_reset();
        recipe = 2'd0; state_in = 3'd0; reset = 1'b1;
        for (int i = 0; i < 60 && remaining != 8'd3; i++) step();
        chk("midcount_reached3", remaining, 8'd3);
        reset = 1'b0;
        step();
        chk("midrst_remaining", remaining, 8'd0);
        chk("midrst_state", timer_state, 2'b00);
        chk("midrst_result", result, 1'b0);

        // Zero dose: sugar with latched recipe 0
        do_reset();
        recipe = 2'd0; state_in = 3'd2; reset = 1'b1;
        step();
        chk("zero_load", timer_state, 2'b01);
        chk("zero_load_active", dose_active, 1'b0);
        step();
        chk("zero_result", result, 1'b1);
        chk("zero_done_state", timer_state, 2'b11);
        chk("zero_done_active", dose_active, 1'b0);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (result || dose_active) npulse++;
        end
        chk("zero_no_repeat", npulse, 0);

        // Abort mid-COUNT: to another ingredient, then to finished
        do_reset();
        recipe = 2'd0; state_in = 3'd0; reset = 1'b1;
        step(); step(); step(); step();
        chk("abort_pre_count", timer_state, 2'b10);
        state_in = 3'd1;
        step();
        chk("abort_to_load", timer_state, 2'b01);
        chk("abort_to_load_result", result, 1'b0);
        step();
        chk("abort_coffee_remaining", remaining, 8'd4);
        state_in = 3'd5;
        step();
        chk("abort_idle", timer_state, 2'b00);
        chk("abort_idle_active", dose_active, 1'b0);
        chk("abort_idle_remaining", remaining, 8'd0);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (result || dose_active) npulse++;
        end
        chk("finished_quiet", npulse, 0);

        // Closed loop, recipe 3
        brew(2'd3, 1'b0);
        chk("r3_pulses", npulse, 5);
        chk("r3_ndoses", nd, 5);
        chk("r3_dose0", doses[0], 8'd6);
        chk("r3_dose1", doses[1], 8'd4);
        chk("r3_dose2", doses[2], 8'd2);
        chk("r3_dose3", doses[3], 8'd4);
        chk("r3_dose4", doses[4], 8'd3);
        chk("r3_final_state_in", state_in, 3'd5);
        step(); step(); step();
        chk("r3_idle", timer_state, 2'b00);
        chk("r3_result_low", result, 1'b0);
        chk("r3_active_low", dose_active, 1'b0);

        // Recipe 2 latched at water; switching to 0 during coffee must not matter
        brew(2'd2, 1'b1);
        chk("r2_pulses", npulse, 5);
        chk("r2_ndoses", nd, 4);
        chk("r2_recipe_switched", recipe, 2'd0);
        chk("r2_milk_dose", doses[3], 8'd6);

`ifdef DOSE_TIMER_PAUSE_EN
        // Pause for 10 cycles mid-dose delays the pulse by 10
        do_reset();
        recipe = 2'd0; state_in = 3'd0; pause = 1'b0; reset = 1'b1;
        step();
        first_off = -1;
        for (int off = 1; off <= 90; off++) begin
            step();
            if (off == 10) begin
                chk("pause_start_remaining", remaining, 8'd6);
                pause = 1'b1;
            end
            if (off == 15) chk("pause_mid_remaining", remaining, 8'd6);
            if (off == 20) begin
                chk("pause_end_remaining", remaining, 8'd6);
                chk("pause_still_active", dose_active, 1'b1);
                pause = 1'b0;
            end
            if (result && first_off < 0) first_off = off;
        end
        chk("pause_pulse_offset", first_off, 43);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
